// File: rtl/tmds_channel_encoder_if.sv
// TMDS channel encoder bus: pixel-side inputs plus encoded symbol outputs.
// Latency: none; this interface only bundles wires.
// Backpressure: none; one symbol per clock with no handshake.
//
// Signals:
//   de     - data enable, 1 = video pixel on data
//   ctrl   - control bits {c1,c0}, used while de=0
//   data   - 8-bit pixel component, used while de=1
//   tmds   - 10-bit encoded symbol, bit 0 transmitted first
//   de_out - de delayed to line up with tmds
interface tmds_channel_encoder_if;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic [9:0] tmds;
    logic       de_out;

    // master drives pixels and consumes symbols (pixel source side)
    modport master (
        output de, ctrl, data,
        input  tmds, de_out
    );

    // slave is the encoder
    modport slave (
        input  de, ctrl, data,
        output tmds, de_out
    );
endinterface

// File: rtl/tmds_channel_encoder.sv
// One TMDS channel: 8b/10b DC-balanced video words while de=1, control tokens while de=0.
// Latency: fixed 3 cycles (input register, transition minimisation, DC balance/output register).
// Backpressure: none; accepts and emits one symbol every clock.
//
// Ports: clock (pixel clock), reset (synchronous, active-high),
//        bus (tmds_channel_encoder_if.slave: de/ctrl/data in, tmds/de_out out).
// Parameter CHANNEL (0..2) only selects the guard-band code.
// Optional macro TMDS_GUARD_BAND_EN: control slots that precede video by one or
// two slots emit the video guard band instead of their control token.
module tmds_channel_encoder #(
    parameter int CHANNEL = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    tmds_channel_encoder_if.slave bus
);

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

`ifdef TMDS_GUARD_BAND_EN
    localparam logic [9:0] GUARD = (CHANNEL == 1) ? 10'b0100110011 : 10'b1011001100;
`endif

    if (CHANNEL < 0 || CHANNEL > 2) begin : g_bad_channel
        $error("tmds_channel_encoder: CHANNEL must be 0..2");
    end

    // stage 0: input register
    logic       r_de0;
    logic [1:0] r_ctrl0;
    logic [7:0] r_data0;

    // stage 1: transition-minimised word
    logic       r_de1;
    logic [1:0] r_ctrl1;
    logic [8:0] r_qm1;

    // stage 2: output register and running disparity
    logic [9:0]        r_tmds;
    logic              r_de_out;
    logic signed [4:0] r_cnt;

    logic [3:0]        w_n1_d;
    logic              w_use_xnor;
    logic [8:0]        w_qm;
    logic [3:0]        w_n1_q;
    logic signed [5:0] w_diff;      // n1 - n0 of q_m[7:0]
    logic signed [5:0] w_cnt;
    logic signed [5:0] w_cnt_next;
    logic [9:0]        w_video;
    logic [9:0]        w_token;

    // Transition minimisation: XNOR chain when the byte is ones-heavy.
    always_comb begin
        w_n1_d     = 4'($countones(r_data0));
        w_use_xnor = (w_n1_d > 4'd4) || ((w_n1_d == 4'd4) && !r_data0[0]);
        w_qm       = '0;
        w_qm[0]    = r_data0[0];
        for (int i = 1; i < 8; i++) begin
            w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ r_data0[i]) : (w_qm[i-1] ^ r_data0[i]);
        end
        w_qm[8] = ~w_use_xnor;
    end

    // DC balance: choose inversion from the sign of the running disparity.
    always_comb begin
        w_n1_q = 4'($countones(r_qm1[7:0]));
        w_diff = $signed({1'b0, w_n1_q, 1'b0}) - 6'sd8;
        w_cnt  = {r_cnt[4], r_cnt};
        if ((w_cnt == 6'sd0) || (w_diff == 6'sd0)) begin
            w_video    = {~r_qm1[8], r_qm1[8], r_qm1[8] ? r_qm1[7:0] : ~r_qm1[7:0]};
            w_cnt_next = w_cnt + (r_qm1[8] ? w_diff : -w_diff);
        end else if (((w_cnt > 6'sd0) && (w_diff > 6'sd0)) ||
                     ((w_cnt < 6'sd0) && (w_diff < 6'sd0))) begin
            w_video    = {1'b1, r_qm1[8], ~r_qm1[7:0]};
            w_cnt_next = w_cnt + (r_qm1[8] ? 6'sd2 : 6'sd0) - w_diff;
        end else begin
            w_video    = {1'b0, r_qm1[8], r_qm1[7:0]};
            w_cnt_next = w_cnt + w_diff - (r_qm1[8] ? 6'sd0 : 6'sd2);
        end
    end

    always_comb begin
        case (r_ctrl1)
            2'b00:   w_token = TOK_00;
            2'b01:   w_token = TOK_01;
            2'b10:   w_token = TOK_10;
            default: w_token = TOK_11;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_de0    <= 1'b0;
            r_ctrl0  <= 2'b00;
            r_data0  <= 8'h00;
            r_de1    <= 1'b0;
            r_ctrl1  <= 2'b00;
            r_qm1    <= 9'h000;
            r_tmds   <= TOK_00;
            r_de_out <= 1'b0;
            r_cnt    <= 5'sd0;
        end else begin
            r_de0    <= bus.de;
            r_ctrl0  <= bus.ctrl;
            r_data0  <= bus.data;
            r_de1    <= r_de0;
            r_ctrl1  <= r_ctrl0;
            r_qm1    <= w_qm;
            r_de_out <= r_de1;
            if (r_de1) begin
                r_tmds <= w_video;
                r_cnt  <= w_cnt_next[4:0];
            end else begin
                // disparity never carries across a control period
                r_cnt <= 5'sd0;
`ifdef TMDS_GUARD_BAND_EN
                // next slot sits in stage 0, the one after is on the input
                if (r_de0 || bus.de) begin
                    r_tmds <= GUARD;
                end else begin
                    r_tmds <= w_token;
                end
`else
                r_tmds <= w_token;
`endif
            end
        end
    end

    assign bus.tmds   = r_tmds;
    assign bus.de_out = r_de_out;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Self-checking bench for tmds_channel_encoder: directed token/data cases plus
// random 1280-pixel lines compared against a behavioural model.
// Outputs are sampled 1 time unit after the rising edge.
module tb_tmds_channel_encoder;

    localparam int CH = 1;

`ifdef TMDS_GUARD_BAND_EN
    localparam bit GB_EN = 1'b1;
`else
    localparam bit GB_EN = 1'b0;
`endif

    typedef struct packed {
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] data;
    } pix_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    tmds_channel_encoder_if bus ();

    tmds_channel_encoder #(.CHANNEL(CH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_bad    = 0;

    logic [9:0] TOK [4];
    pix_t       pend [$];
    int         mcnt;
    int         obs_disp = 0;
    logic [9:0] obs_t [$];
    int         obs_d [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ones(input logic [9:0] v);
        int n = 0;
        for (int i = 0; i < 10; i++) n += int'(v[i]);
        return n;
    endfunction

    // Reference encoder. The running disparity is tracked as the plain
    // ones-minus-zeros sum of the emitted 10-bit video symbols.
    function automatic logic [9:0] model_enc(input pix_t p, input logic gb);
        logic [8:0] qm;
        logic [9:0] sym;
        int         n, bal;
        logic       xn;
        if (!p.de) begin
            mcnt = 0;
            if (gb) return (CH == 1) ? 10'b0100110011 : 10'b1011001100;
            return TOK[p.ctrl];
        end
        n  = ones({2'b00, p.data});
        xn = (n > 4) || (n == 4 && !p.data[0]);
        qm[0] = p.data[0];
        for (int i = 1; i < 8; i++)
            qm[i] = xn ? !(qm[i-1] ^ p.data[i]) : (qm[i-1] ^ p.data[i]);
        qm[8] = !xn;
        bal = 2 * ones({2'b00, qm[7:0]}) - 8;
        if (mcnt == 0 || bal == 0)
            sym = qm[8] ? {2'b01, qm[7:0]} : {2'b10, ~qm[7:0]};
        else if ((mcnt > 0 && bal > 0) || (mcnt < 0 && bal < 0))
            sym = {1'b1, qm[8], ~qm[7:0]};
        else
            sym = {1'b0, qm[8], qm[7:0]};
        mcnt += 2 * ones(sym) - 10;
        return sym;
    endfunction

    task automatic step(input logic rst, input logic de, input logic [1:0] ctrl, input logic [7:0] data);
        pix_t       e, cur, z;
        logic [9:0] et;
        logic       ed, gb;
        z = '0;
        @(negedge clock);
        reset    = rst;
        bus.de   = de;
        bus.ctrl = ctrl;
        bus.data = data;
        @(posedge clock);
        #1;
        if (rst) begin
            pend.delete();
            pend.push_back(z);
            pend.push_back(z);
            mcnt = 0;
            et   = TOK[0];
            ed   = 1'b0;
        end else begin
            cur.de = de; cur.ctrl = ctrl; cur.data = data;
            pend.push_back(cur);
            e  = pend.pop_front();
            gb = GB_EN && !e.de && (pend[0].de || pend[1].de);
            et = model_enc(e, gb);
            ed = e.de;
        end
        chk("tmds", {22'd0, bus.tmds}, {22'd0, et});
        chk("de_out", {31'd0, bus.de_out}, {31'd0, ed});
        if (bus.de_out === 1'b1) begin
            obs_disp += 2 * ones(bus.tmds) - 10;
            chk("disp_bound", {31'd0, (obs_disp <= 10 && obs_disp >= -10)}, 32'd1);
            chk("disp_vs_model", obs_disp, mcnt);
        end else begin
            obs_disp = 0;
        end
        obs_t.push_back(bus.tmds);
        obs_d.push_back(obs_disp);
    endtask

    initial begin
        int base;
        logic [1:0] vh;
        TOK[0] = 10'b1101010100;
        TOK[1] = 10'b0010101011;
        TOK[2] = 10'b0101010100;
        TOK[3] = 10'b1010101011;
        bus.de = 1'b0; bus.ctrl = 2'b00; bus.data = 8'h00;
        mcnt = 0;

        // reset state
        repeat (3) step(1'b1, 1'b0, 2'b00, 8'h00);
        chk("reset_tmds", {22'd0, bus.tmds}, {22'd0, 10'b1101010100});
        chk("reset_de_out", {31'd0, bus.de_out}, 32'd0);
        repeat (6) step(1'b0, 1'b0, 2'b00, 8'h00);
        chk("idle_tmds", {22'd0, bus.tmds}, {22'd0, 10'b1101010100});

        // control tokens in order
        base = obs_t.size();
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 2'(c), 8'h00);
        repeat (4) step(1'b0, 1'b0, 2'b00, 8'h00);
        chk("tok00", {22'd0, obs_t[base+2]}, {22'd0, 10'b1101010100});
        chk("tok01", {22'd0, obs_t[base+3]}, {22'd0, 10'b0010101011});
        chk("tok10", {22'd0, obs_t[base+4]}, {22'd0, 10'b0101010100});
        chk("tok11", {22'd0, obs_t[base+5]}, {22'd0, 10'b1010101011});

        // three 0x00 pixels after a control period
        base = obs_t.size();
        repeat (3) step(1'b0, 1'b1, 2'b00, 8'h00);
        repeat (4) step(1'b0, 1'b0, 2'b00, 8'h00);
        chk("z0_tmds", {22'd0, obs_t[base+2]}, {22'd0, 10'b0100000000});
        chk("z0_cnt", obs_d[base+2], -8);
        chk("z1_tmds", {22'd0, obs_t[base+3]}, {22'd0, 10'b1111111111});
        chk("z1_cnt", obs_d[base+3], 2);
        chk("z2_tmds", {22'd0, obs_t[base+4]}, {22'd0, 10'b0100000000});
        chk("z2_cnt", obs_d[base+4], -6);

        // single 0xFF pixel after a control period
        base = obs_t.size();
        step(1'b0, 1'b1, 2'b00, 8'hFF);
        repeat (4) step(1'b0, 1'b0, 2'b00, 8'h00);
        chk("ff_tmds", {22'd0, obs_t[base+2]}, {22'd0, 10'b1000000000});
        chk("ff_cnt", obs_d[base+2], -8);

`ifdef TMDS_GUARD_BAND_EN
        // guard band before video, then a one-slot gap
        base = obs_t.size();
        repeat (10) step(1'b0, 1'b0, 2'b00, 8'h00);
        step(1'b0, 1'b1, 2'b00, 8'h55);
        step(1'b0, 1'b0, 2'b00, 8'h00);
        step(1'b0, 1'b1, 2'b00, 8'hA3);
        repeat (4) step(1'b0, 1'b0, 2'b00, 8'h00);
        chk("gb_pre0", {22'd0, obs_t[base+9]}, {22'd0, 10'b1101010100});
        chk("gb_pre1", {22'd0, obs_t[base+10]}, {22'd0, 10'b0100110011});
        chk("gb_pre2", {22'd0, obs_t[base+11]}, {22'd0, 10'b0100110011});
        chk("gb_gap", {22'd0, obs_t[base+13]}, {22'd0, 10'b0100110011});
`endif

        // random lines; a reset lands mid-line in the second one
        for (int l = 0; l < 3; l++) begin
            repeat ($urandom_range(2, 20)) begin
                vh = 2'($urandom);
                step(1'b0, 1'b0, vh, 8'($urandom));
            end
            for (int px = 0; px < 1280; px++) begin
                if (l == 1 && px == 600) begin
                    step(1'b1, 1'b1, 2'b00, 8'($urandom));
                    chk("midreset_tmds", {22'd0, bus.tmds}, {22'd0, 10'b1101010100});
                end else begin
                    step(1'b0, 1'b1, 2'b00, 8'($urandom));
                end
            end
        end

        // de toggling freely
        repeat (200) step(1'b0, 1'($urandom), 2'($urandom), 8'($urandom));
        repeat (5) step(1'b0, 1'b0, 2'b00, 8'h00);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
